// File: rtl/mac_sched.sv
// mac_sched
//   Job sequencer for one MAC processing element (8 accumulators, 3 activation
//   lanes, 1 weight). A job config is latched on start. The sequencer clears the
//   PE, streams operand-buffer reads, and sends the matching one-hot lane valid
//   and accumulator select into the PE, aligned with the returned read data. It
//   counts PE results and then pulses done. err is raised with done when the
//   config is bad or when the result count does not match the issue count.
//
// Ports
//   clk, rst_n       clock (rising edge), async active-low reset
//   start, abort     job request (sampled in IDLE), sync abort (non-IDLE only)
//   cfg_k            reduction length per accumulator
//   cfg_nacc         accumulators used (1..NUM_ACC)
//   cfg_lane_mask    enabled activation lanes
//   op_ready         operand buffer accepts a read this cycle
//   op_rd_en/op_addr operand read strobe / address (wraps)
//   mac_clear        PE clear
//   mac_valid_ctrl   PE lane valid, one-hot or zero
//   mac_acc_sel      PE accumulator select, holds when mac_valid_ctrl is 0
//   res_valid        PE result strobe
//   busy, done, err  job status
//
// state | meaning
// IDLE  | waiting for start, config latched on start
// CLEAR | one-cycle PE clear, counters and address zeroed
// RUN   | issuing reads, one per op_ready cycle
// DRAIN | RD_LAT+1 cycles for delay line and PE register to empty
// DONE  | one-cycle done pulse, err valid

module mac_sched #(
    parameter int NUM_ACC = 8,
    parameter int K_W     = 8,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [K_W-1:0]    cfg_k,
    input  logic [3:0]        cfg_nacc,
    input  logic [2:0]        cfg_lane_mask,
    input  logic              op_ready,
    output logic              op_rd_en,
    output logic [ADDR_W-1:0] op_addr,
    output logic              mac_clear,
    output logic [2:0]        mac_valid_ctrl,
    output logic [2:0]        mac_acc_sel,
    input  logic              res_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Wide enough for K * nacc * 3 lanes.
    localparam int CNT_W = K_W + 6;
    localparam logic [3:0] NACC_MAX = 4'(NUM_ACC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_cfg_q, k_cfg_d;
    logic [3:0]        nacc_q, nacc_d;
    logic [2:0]        mask_q, mask_d;
    logic [2:0]        acc_q, acc_d;
    logic [K_W-1:0]    k_rem_q, k_rem_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [2:0]        drain_q, drain_d;
    logic              err_q, err_d;
    logic [2:0]        acc_hold_q, acc_hold_d;
    logic [2:0]        dl_vld_q [RD_LAT];
    logic [2:0]        dl_vld_d [RD_LAT];
    logic [2:0]        dl_acc_q [RD_LAT];
    logic [2:0]        dl_acc_d [RD_LAT];

    logic              issue;
    logic              abort_hit;
    logic              cfg_bad;
    logic [2:0]        lane_above;
    logic [2:0]        acc_last;
    logic [1:0]        lane_pop;
    logic [CNT_W-1:0]  n_total;

    // Index of the lowest set bit; callers never pass zero.
    function automatic logic [1:0] low_lane(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Enabled lanes strictly above the current lane.
    function automatic logic [2:0] above_lanes(input logic [2:0] m, input logic [1:0] l);
        case (l)
            2'd0:    return m & 3'b110;
            2'd1:    return m & 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign cfg_bad  = (cfg_k == '0) || (cfg_nacc == 4'd0) ||
                      (cfg_nacc > NACC_MAX) || (cfg_lane_mask == 3'b000);
    assign acc_last = 3'(nacc_q - 4'd1);
    assign lane_pop = 2'({1'b0, mask_q[0]} + {1'b0, mask_q[1]} + {1'b0, mask_q[2]});
    assign n_total  = CNT_W'(k_cfg_q) * CNT_W'(nacc_q) * CNT_W'(lane_pop);

    always_comb begin
        state_d    = state_q;
        k_cfg_d    = k_cfg_q;
        nacc_d     = nacc_q;
        mask_d     = mask_q;
        acc_d      = acc_q;
        k_rem_d    = k_rem_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        res_cnt_d  = res_cnt_q;
        drain_d    = drain_q;
        err_d      = err_q;
        issue      = 1'b0;
        abort_hit  = abort && (state_q != ST_IDLE);
        lane_above = above_lanes(mask_q, lane_q);

        // Result counter saturates so a misbehaving PE cannot wrap it back to N.
        if ((state_q == ST_RUN || state_q == ST_DRAIN) && res_valid && (res_cnt_q != '1)) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_cfg_d = cfg_k;
                    nacc_d  = cfg_nacc;
                    mask_d  = cfg_lane_mask;
                    if (cfg_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                acc_d     = 3'd0;
                k_rem_d   = k_cfg_q - K_W'(1);
                lane_d    = low_lane(mask_q);
                addr_d    = '0;
                res_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (op_ready && !abort_hit) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (lane_above != 3'b000) begin
                        lane_d = low_lane(lane_above);
                    end else begin
                        lane_d = low_lane(mask_q);
                        if (k_rem_q == '0) begin
                            k_rem_d = k_cfg_q - K_W'(1);
                            acc_d   = acc_q + 3'd1;
                            if (acc_q == acc_last) begin
                                drain_d = 3'(RD_LAT);
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            k_rem_d = k_rem_q - K_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 3'd0) begin
                    // Uses res_cnt_d so a result landing in the last drain cycle counts.
                    err_d   = (res_cnt_d != n_total);
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Lane/acc delay line that matches the operand-buffer read latency.
    always_comb begin
        dl_vld_d[0] = issue ? (3'b001 << lane_q) : 3'b000;
        dl_acc_d[0] = acc_q;
        for (int i = 1; i < RD_LAT; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_acc_d[i] = dl_acc_q[i-1];
        end
        if (abort_hit) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dl_vld_d[i] = 3'b000;
            end
        end
    end

    assign mac_valid_ctrl = dl_vld_q[RD_LAT-1];
    assign mac_acc_sel    = (dl_vld_q[RD_LAT-1] != 3'b000) ? dl_acc_q[RD_LAT-1] : acc_hold_q;
    assign acc_hold_d     = mac_acc_sel;

    assign op_rd_en  = issue;
    assign op_addr   = addr_q;
    assign mac_clear = (state_q == ST_CLEAR);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_DONE) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_cfg_q    <= '0;
            nacc_q     <= 4'd0;
            mask_q     <= 3'b000;
            acc_q      <= 3'd0;
            k_rem_q    <= '0;
            lane_q     <= 2'd0;
            addr_q     <= '0;
            res_cnt_q  <= '0;
            drain_q    <= 3'd0;
            err_q      <= 1'b0;
            acc_hold_q <= 3'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                dl_vld_q[i] <= 3'b000;
                dl_acc_q[i] <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            k_cfg_q    <= k_cfg_d;
            nacc_q     <= nacc_d;
            mask_q     <= mask_d;
            acc_q      <= acc_d;
            k_rem_q    <= k_rem_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            res_cnt_q  <= res_cnt_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
            acc_hold_q <= acc_hold_d;
            for (int i = 0; i < RD_LAT; i++) begin
                dl_vld_q[i] <= dl_vld_d[i];
                dl_acc_q[i] <= dl_acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched
//   Directed bench for mac_sched with default parameters (RD_LAT=1). A small
//   PE stand-in returns res_valid one cycle after a nonzero mac_valid_ctrl.
//   Cycle numbering: c0 is the cycle where start is high.

module tb_mac_sched;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        cfg_k = 8'd0;
    logic [3:0]        cfg_nacc = 4'd0;
    logic [2:0]        cfg_lane_mask = 3'b000;
    logic              op_ready = 1'b0;
    logic              op_rd_en;
    logic [ADDR_W-1:0] op_addr;
    logic              mac_clear;
    logic [2:0]        mac_valid_ctrl;
    logic [2:0]        mac_acc_sel;
    logic              res_valid;
    logic              busy;
    logic              done;
    logic              err;
    logic              pe_en = 1'b1;

    mac_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_k          (cfg_k),
        .cfg_nacc       (cfg_nacc),
        .cfg_lane_mask  (cfg_lane_mask),
        .op_ready       (op_ready),
        .op_rd_en       (op_rd_en),
        .op_addr        (op_addr),
        .mac_clear      (mac_clear),
        .mac_valid_ctrl (mac_valid_ctrl),
        .mac_acc_sel    (mac_acc_sel),
        .res_valid      (res_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    // PE stand-in: registered result strobe, can be tied low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_valid <= 1'b0;
        else        res_valid <= pe_en & (|mac_valid_ctrl);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         rd_cnt, clear_cnt, addr_bad, rd_notready, misalign;
    int         done_cyc, done_cnt;
    logic       done_err;
    logic       rd_prev;
    logic [2:0] vq [$];
    logic [2:0] aq [$];

    // Starts a job and observes it until done or the cycle budget runs out.
    // mode 0: op_ready always 1; mode 1: op_ready high on even cycles only.
    task automatic run_job(input logic [7:0] k, input logic [3:0] nacc, input logic [2:0] mask,
                           input int mode, input int budget);
        rd_cnt = 0; clear_cnt = 0; addr_bad = 0; rd_notready = 0; misalign = 0;
        done_cyc = -1; done_cnt = 0; done_err = 1'b0; rd_prev = 1'b0;
        vq.delete();
        aq.delete();
        cfg_k = k; cfg_nacc = nacc; cfg_lane_mask = mask;
        op_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            op_ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
            #1;
            if (mac_clear) clear_cnt++;
            if (op_rd_en) begin
                if (!op_ready) rd_notready++;
                if (op_addr != ADDR_W'(rd_cnt)) addr_bad++;
                rd_cnt++;
            end
            if ((mac_valid_ctrl != 3'b000) != rd_prev) misalign++;
            if (mac_valid_ctrl != 3'b000) begin
                vq.push_back(mac_valid_ctrl);
                aq.push_back(mac_acc_sel);
            end
            rd_prev = op_rd_en;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                done_err = err;
                tick();
                break;
            end
            tick();
        end
        op_ready = 1'b1;
    endtask

    logic [7:0] bad_k    [4] = '{8'd2, 8'd0, 8'd2, 8'd2};
    logic [3:0] bad_nacc [4] = '{4'd9, 4'd1, 4'd1, 4'd0};
    logic [2:0] bad_mask [4] = '{3'b001, 3'b001, 3'b000, 3'b001};

    initial begin
        int dn;
        int lim;

        // Reset values
        #12;
        check_val("rst_rd_en", op_rd_en, 0);
        check_val("rst_addr", op_addr, 0);
        check_val("rst_clear", mac_clear, 0);
        check_val("rst_valid", mac_valid_ctrl, 0);
        check_val("rst_acc_sel", mac_acc_sel, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Single-lane, K=2 cycle-exact walk
        cfg_k = 8'd2; cfg_nacc = 4'd1; cfg_lane_mask = 3'b001; op_ready = 1'b1;
        start = 1'b1;
        #1;
        check_val("t1_c0_busy", busy, 0);
        tick();
        start = 1'b0;
        check_val("t1_c1_clear", mac_clear, 1);
        check_val("t1_c1_rd", op_rd_en, 0);
        check_val("t1_c1_busy", busy, 1);
        tick();
        check_val("t1_c2_rd", op_rd_en, 1);
        check_val("t1_c2_addr", op_addr, 0);
        check_val("t1_c2_valid", mac_valid_ctrl, 0);
        check_val("t1_c2_clear", mac_clear, 0);
        tick();
        check_val("t1_c3_rd", op_rd_en, 1);
        check_val("t1_c3_addr", op_addr, 1);
        check_val("t1_c3_valid", mac_valid_ctrl, 1);
        check_val("t1_c3_acc", mac_acc_sel, 0);
        tick();
        check_val("t1_c4_rd", op_rd_en, 0);
        check_val("t1_c4_valid", mac_valid_ctrl, 1);
        tick();
        check_val("t1_c5_valid", mac_valid_ctrl, 0);
        check_val("t1_c5_done", done, 0);
        check_val("t1_c5_busy", busy, 1);
        tick();
        check_val("t1_c6_done", done, 1);
        check_val("t1_c6_err", err, 0);
        tick();
        check_val("t1_c7_done", done, 0);
        check_val("t1_c7_busy", busy, 0);

        // Two accumulators, lanes 0 and 2
        run_job(8'd3, 4'd2, 3'b101, 0, 60);
        check_val("t2_done_cnt", done_cnt, 1);
        check_val("t2_done_cyc", done_cyc, 16);
        check_val("t2_err", done_err, 0);
        check_val("t2_clear_cnt", clear_cnt, 1);
        check_val("t2_rd_cnt", rd_cnt, 12);
        check_val("t2_addr_bad", addr_bad, 0);
        check_val("t2_misalign", misalign, 0);
        check_val("t2_nvalid", vq.size(), 12);
        lim = (vq.size() < 12) ? vq.size() : 12;
        for (int i = 0; i < lim; i++) begin
            check_val($sformatf("t2_lane%0d", i), vq[i], (i % 2 == 0) ? 3'b001 : 3'b100);
            check_val($sformatf("t2_acc%0d", i), aq[i], (i < 6) ? 0 : 1);
        end
        check_val("t2_after_busy", busy, 0);
        check_val("t2_acc_hold", mac_acc_sel, 1);

        // op_ready alternating, lanes 0 and 1
        run_job(8'd2, 4'd1, 3'b011, 1, 60);
        check_val("t3_done_cnt", done_cnt, 1);
        check_val("t3_done_cyc", done_cyc, 11);
        check_val("t3_err", done_err, 0);
        check_val("t3_rd_cnt", rd_cnt, 4);
        check_val("t3_rd_notready", rd_notready, 0);
        check_val("t3_addr_bad", addr_bad, 0);
        check_val("t3_misalign", misalign, 0);
        check_val("t3_nvalid", vq.size(), 4);
        lim = (vq.size() < 4) ? vq.size() : 4;
        for (int i = 0; i < lim; i++) begin
            check_val($sformatf("t3_lane%0d", i), vq[i], (i % 2 == 0) ? 3'b001 : 3'b010);
        end

        // Bad configs: nacc=9, k=0, mask=0, nacc=0
        for (int b = 0; b < 4; b++) begin
            cfg_k = bad_k[b]; cfg_nacc = bad_nacc[b]; cfg_lane_mask = bad_mask[b];
            start = 1'b1;
            tick();
            start = 1'b0;
            check_val($sformatf("t4_%0d_done", b), done, 1);
            check_val($sformatf("t4_%0d_err", b), err, 1);
            check_val($sformatf("t4_%0d_clear", b), mac_clear, 0);
            check_val($sformatf("t4_%0d_rd", b), op_rd_en, 0);
            tick();
            check_val($sformatf("t4_%0d_done2", b), done, 0);
            check_val($sformatf("t4_%0d_busy2", b), busy, 0);
        end

        // Abort mid-RUN, then a clean job
        cfg_k = 8'd4; cfg_nacc = 4'd2; cfg_lane_mask = 3'b111; op_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_val("t5_pre_rd", op_rd_en, 1);
        abort = 1'b1;
        #1;
        check_val("t5_abort_rd", op_rd_en, 0);
        tick();
        abort = 1'b0;
        check_val("t5_post_rd", op_rd_en, 0);
        check_val("t5_post_valid", mac_valid_ctrl, 0);
        check_val("t5_post_busy", busy, 0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            tick();
        end
        check_val("t5_no_done", dn, 0);
        run_job(8'd2, 4'd1, 3'b001, 0, 40);
        check_val("t5_next_done_cyc", done_cyc, 6);
        check_val("t5_next_err", done_err, 0);
        check_val("t5_next_rd_cnt", rd_cnt, 2);
        check_val("t5_next_addr_bad", addr_bad, 0);

        // res_valid tied low
        pe_en = 1'b0;
        run_job(8'd1, 4'd1, 3'b001, 0, 30);
        check_val("t6_done_cnt", done_cnt, 1);
        check_val("t6_done_cyc", done_cyc, 5);
        check_val("t6_err", done_err, 1);
        pe_en = 1'b1;

        // Reset mid-RUN
        cfg_k = 8'd4; cfg_nacc = 4'd1; cfg_lane_mask = 3'b001; op_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_val("t7_pre_rd", op_rd_en, 1);
        rst_n = 1'b0;
        #1;
        check_val("t7_rst_rd", op_rd_en, 0);
        check_val("t7_rst_addr", op_addr, 0);
        check_val("t7_rst_valid", mac_valid_ctrl, 0);
        check_val("t7_rst_busy", busy, 0);
        check_val("t7_rst_clear", mac_clear, 0);
        tick();
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            tick();
        end
        check_val("t7_no_done", dn, 0);
        check_val("t7_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
